// File: rtl/mfi_causal_monitor_pkg.sv
// Shared types and helpers for the MFI retirement-order causality monitor.
//   mon_state_e : monitor FSM encoding (IDLE, ARMED, DONE, TOUT)
//   popcount    : number of set bits in a channel vector (up to MAX_NRET channels)
package mfi_causal_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2,
    TOUT  = 2'd3
  } mon_state_e;

  localparam int unsigned MAX_NRET = 32;
  localparam int unsigned POP_W    = 6;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_NRET-1:0] vec);
    logic [POP_W-1:0] n;
    n = {POP_W{1'b0}};
    for (int i = 0; i < int'(MAX_NRET); i++) begin
      n = n + {{(POP_W-1){1'b0}}, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mfi_causal_monitor_if.sv
// Retire-bus and target-arming bundle observed by the causality monitor.
//   arm, tgt_order, tgt_reg : target arming request
//   mfi_valid/order/src_addr/dest_addr : per-channel retire beat, channel 0 in LSBs
// master drives the bundle (bench / core), slave observes it (monitor).
interface mfi_causal_monitor_if #(
  parameter int unsigned NRET    = 1,
  parameter int unsigned ORDER_W = 32,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned NSRC    = 3
);
  logic                        arm;
  logic [ORDER_W-1:0]          tgt_order;
  logic [REG_W-1:0]            tgt_reg;
  logic [NRET-1:0]             mfi_valid;
  logic [NRET*ORDER_W-1:0]     mfi_order;
  logic [NRET*NSRC*REG_W-1:0]  mfi_src_addr;
  logic [NRET*REG_W-1:0]       mfi_dest_addr;

  modport master (
    output arm, tgt_order, tgt_reg,
    output mfi_valid, mfi_order, mfi_src_addr, mfi_dest_addr
  );

  modport slave (
    input arm, tgt_order, tgt_reg,
    input mfi_valid, mfi_order, mfi_src_addr, mfi_dest_addr
  );
endinterface

// File: rtl/mfi_causal_monitor_chan_match.sv
// Per-channel combinational detect against the latched target.
//   valid, order, src_addr, dest_addr : one retire channel
//   tgt_order, tgt_reg                : latched target
//   reader : younger instruction reads the target register
//   hit    : this beat is the target instruction retiring
module mfi_chan_match #(
  parameter int unsigned ORDER_W = 32,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned NSRC    = 3
) (
  input  logic                    valid,
  input  logic [ORDER_W-1:0]      order,
  input  logic [NSRC*REG_W-1:0]   src_addr,
  input  logic [REG_W-1:0]        dest_addr,
  input  logic [ORDER_W-1:0]      tgt_order,
  input  logic [REG_W-1:0]        tgt_reg,
  output logic                    reader,
  output logic                    hit
);

  logic src_match_s;
  logic reg_ok_s;

  // x0 is hardwired and can never carry a dependency
  assign reg_ok_s = (tgt_reg != {REG_W{1'b0}});

  // OR-reduce the source-operand compares
  always_comb begin
    src_match_s = 1'b0;
    for (int s = 0; s < int'(NSRC); s++) begin
      src_match_s = src_match_s | (src_addr[s*REG_W +: REG_W] == tgt_reg);
    end
  end

  assign reader = valid && reg_ok_s && src_match_s && (order > tgt_order);
  assign hit    = valid && reg_ok_s && (order == tgt_order) && (dest_addr == tgt_reg);

endmodule

// File: rtl/mfi_causal_monitor_chk.sv
// Formal/sim checker: once the target has retired, no non-causal read may have been seen.
//   clock, reset_n : monitor clock and reset
//   state          : monitor FSM state
//   violation      : sticky violation flag
module mfi_causal_monitor_chk
  import mfi_causal_monitor_pkg::*;
(
  input logic       clock,
  input logic       reset_n,
  input mon_state_e state,
  input logic       violation
);

  a_no_violation_when_done: assert property (
    @(posedge clock) disable iff (!reset_n) (state == DONE) |-> !violation
  );

endmodule

// File: rtl/mfi_causal_monitor.sv
// Retirement-order causality monitor on the MFI retire bus.
// Armed with a target (order, register), it flags any younger instruction that reads
// the target register strictly before the target retires.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus            : arm/target request and retire channels (slave modport)
//   armed, done, pass, violation, timeout, arm_err : registered status flags
//   viol_count     : saturating count of non-causal reads
//   first_viol_ord : order of the first offending reader
module mfi_causal_monitor
  import mfi_causal_monitor_pkg::*;
#(
  parameter int unsigned NRET      = 1,
  parameter int unsigned ORDER_W   = 32,
  parameter int unsigned REG_W     = 4,
  parameter int unsigned NSRC      = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned ASSERT_EN = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  mfi_causal_monitor_if.slave bus,
  output logic                armed,
  output logic                done,
  output logic                pass,
  output logic                violation,
  output logic                timeout,
  output logic                arm_err,
  output logic [CNT_W-1:0]    viol_count,
  output logic [ORDER_W-1:0]  first_viol_ord
);

  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TLIM_M1 = TCNT_W'(TIMEOUT) - TCNT_W'(1);
  localparam bit TOUT_EN = (TIMEOUT != 0);
  localparam int unsigned SUM_W = CNT_W + POP_W;

  mon_state_e          state_r, state_nxt_s;
  logic [ORDER_W-1:0]  tord_r, tord_nxt_s;
  logic [REG_W-1:0]    treg_r, treg_nxt_s;
  logic [TCNT_W-1:0]   tcnt_r, tcnt_nxt_s;
  logic                done_nxt_s, pass_nxt_s, viol_nxt_s, tout_nxt_s, err_nxt_s;
  logic [CNT_W-1:0]    cnt_nxt_s, cnt_sat_s;
  logic [ORDER_W-1:0]  fvo_nxt_s, first_ord_s;
  logic [NRET-1:0]     reader_s, hit_s;
  logic [POP_W-1:0]    pop_s;
  logic [SUM_W-1:0]    sum_s;

  for (genvar c = 0; c < NRET; c++) begin : g_chan
    mfi_chan_match #(
      .ORDER_W (ORDER_W),
      .REG_W   (REG_W),
      .NSRC    (NSRC)
    ) u_match (
      .valid     (bus.mfi_valid[c]),
      .order     (bus.mfi_order[c*ORDER_W +: ORDER_W]),
      .src_addr  (bus.mfi_src_addr[c*NSRC*REG_W +: NSRC*REG_W]),
      .dest_addr (bus.mfi_dest_addr[c*REG_W +: REG_W]),
      .tgt_order (tord_r),
      .tgt_reg   (treg_r),
      .reader    (reader_s[c]),
      .hit       (hit_s[c])
    );
  end

  // Order of the lowest-index reader: scan high to low so channel 0 wins last
  always_comb begin
    first_ord_s = {ORDER_W{1'b0}};
    for (int c = int'(NRET) - 1; c >= 0; c--) begin
      first_ord_s = reader_s[c] ? bus.mfi_order[c*ORDER_W +: ORDER_W] : first_ord_s;
    end
  end

  // Saturating add of this beat's reader count
  always_comb begin
    pop_s     = popcount(MAX_NRET'(reader_s));
    sum_s     = SUM_W'(viol_count) + SUM_W'(pop_s);
    cnt_sat_s = (sum_s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s = state_r;
    tord_nxt_s  = tord_r;
    treg_nxt_s  = treg_r;
    tcnt_nxt_s  = tcnt_r;
    done_nxt_s  = done;
    pass_nxt_s  = pass;
    viol_nxt_s  = violation;
    tout_nxt_s  = timeout;
    err_nxt_s   = arm_err;
    cnt_nxt_s   = viol_count;
    fvo_nxt_s   = first_viol_ord;

    if (bus.arm && (bus.tgt_reg != {REG_W{1'b0}})) begin
      // (Re-)arm from any state: new target, fresh statistics
      state_nxt_s = ARMED;
      tord_nxt_s  = bus.tgt_order;
      treg_nxt_s  = bus.tgt_reg;
      tcnt_nxt_s  = {TCNT_W{1'b0}};
      done_nxt_s  = 1'b0;
      pass_nxt_s  = 1'b0;
      viol_nxt_s  = 1'b0;
      tout_nxt_s  = 1'b0;
      err_nxt_s   = 1'b0;
      cnt_nxt_s   = {CNT_W{1'b0}};
      fvo_nxt_s   = {ORDER_W{1'b0}};
    end else begin
      // A rejected arm (x0 target) only raises arm_err; the current watch continues
      err_nxt_s = arm_err | bus.arm;
      case (state_r)
        ARMED: begin
          if (|hit_s) begin
            // Readers retiring alongside the target are causal
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
            pass_nxt_s  = !violation;
          end else begin
            if (|reader_s) begin
              viol_nxt_s = 1'b1;
              cnt_nxt_s  = cnt_sat_s;
              fvo_nxt_s  = violation ? first_viol_ord : first_ord_s;
            end else begin
              viol_nxt_s = violation;
            end
            if (TOUT_EN && (tcnt_r == TLIM_M1)) begin
              state_nxt_s = TOUT;
              tout_nxt_s  = 1'b1;
            end else begin
              tcnt_nxt_s = tcnt_r + TCNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      tord_r         <= {ORDER_W{1'b0}};
      treg_r         <= {REG_W{1'b0}};
      tcnt_r         <= {TCNT_W{1'b0}};
      armed          <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      violation      <= 1'b0;
      timeout        <= 1'b0;
      arm_err        <= 1'b0;
      viol_count     <= {CNT_W{1'b0}};
      first_viol_ord <= {ORDER_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      tord_r         <= tord_nxt_s;
      treg_r         <= treg_nxt_s;
      tcnt_r         <= tcnt_nxt_s;
      armed          <= (state_nxt_s == ARMED);
      done           <= done_nxt_s;
      pass           <= pass_nxt_s;
      violation      <= viol_nxt_s;
      timeout        <= tout_nxt_s;
      arm_err        <= err_nxt_s;
      viol_count     <= cnt_nxt_s;
      first_viol_ord <= fvo_nxt_s;
    end
  end

  if (ASSERT_EN != 0) begin : g_chk
    mfi_causal_monitor_chk u_chk (
      .clock     (clock),
      .reset_n   (reset_n),
      .state     (state_r),
      .violation (violation)
    );
  end

endmodule

// File: tb/tb_mfi_causal_monitor.sv
// Directed, table-driven bench for mfi_causal_monitor (2 channels, 2-bit counter, timeout 8).
module tb_mfi_causal_monitor;

  logic        clock;
  logic        reset_n;
  logic        armed, done, pass, violation, timeout, arm_err;
  logic [1:0]  viol_count;
  logic [31:0] first_viol_ord;

  int checks = 0;
  int errors = 0;

  mfi_causal_monitor_if #(.NRET(2), .ORDER_W(32), .REG_W(4), .NSRC(3)) bus ();

  mfi_causal_monitor #(
    .NRET(2), .ORDER_W(32), .REG_W(4), .NSRC(3),
    .CNT_W(2), .TIMEOUT(8), .ASSERT_EN(0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .bus            (bus),
    .armed          (armed),
    .done           (done),
    .pass           (pass),
    .violation      (violation),
    .timeout        (timeout),
    .arm_err        (arm_err),
    .viol_count     (viol_count),
    .first_viol_ord (first_viol_ord)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        arm;
    logic [31:0] t_ord;
    logic [3:0]  t_reg;
    logic [1:0]  v;
    logic [31:0] o0;
    logic [11:0] s0;
    logic [3:0]  d0;
    logic [31:0] o1;
    logic [11:0] s1;
    logic [3:0]  d1;
    logic [39:0] exp;
  } vec_t;

  // expected = {armed, done, pass, violation, timeout, arm_err, viol_count, first_viol_ord}
  function automatic logic [39:0] ex(input logic a, input logic d, input logic p,
                                     input logic vi, input logic t, input logic e,
                                     input logic [1:0] c, input logic [31:0] f);
    return {a, d, p, vi, t, e, c, f};
  endfunction

  function automatic vec_t mk(input logic arm, input logic [31:0] t_ord, input logic [3:0] t_reg,
                              input logic [1:0] v,
                              input logic [31:0] o0, input logic [11:0] s0, input logic [3:0] d0,
                              input logic [31:0] o1, input logic [11:0] s1, input logic [3:0] d1,
                              input logic [39:0] exp);
    vec_t r;
    r.arm = arm; r.t_ord = t_ord; r.t_reg = t_reg; r.v = v;
    r.o0 = o0; r.s0 = s0; r.d0 = d0; r.o1 = o1; r.s1 = s1; r.d1 = d1;
    r.exp = exp;
    return r;
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 32'd0, 4'd0, 2'b00, 32'd0, 12'h000, 4'd0, 32'd0, 12'h000, 4'd0, 40'd0);
  endfunction

  task automatic apply(input vec_t r);
    @(negedge clock);
    bus.arm           = r.arm;
    bus.tgt_order     = r.t_ord;
    bus.tgt_reg       = r.t_reg;
    bus.mfi_valid     = r.v;
    bus.mfi_order     = {r.o1, r.o0};
    bus.mfi_src_addr  = {r.s1, r.s0};
    bus.mfi_dest_addr = {r.d1, r.d0};
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [39:0] exp);
    logic [39:0] act;
    act = {armed, done, pass, violation, timeout, arm_err, viol_count, first_viol_ord};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got a/d/p/v/t/e=%b cnt=%0d fvo=%0d, expected a/d/p/v/t/e=%b cnt=%0d fvo=%0d",
               name, act[39:34], act[33:32], act[31:0], exp[39:34], exp[33:32], exp[31:0]);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // T1: one-channel violation, target retires later
    tbl.push_back(mk(1, 10, 5, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, ex(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, ex(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0, 2'b01, 11, 12'h005, 1, 0, 12'h000, 0, ex(1,0,0,1,0,0,1,11)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, ex(1,0,0,1,0,0,1,11)));
    tbl.push_back(mk(0, 0, 0, 2'b01, 10, 12'h000, 5, 0, 12'h000, 0, ex(0,1,0,1,0,0,1,11)));
    // T2: reader in the same beat as the target is causal
    tbl.push_back(mk(1, 10, 5, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, ex(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0, 2'b11, 10, 12'h000, 5, 11, 12'h500, 2, ex(0,1,1,0,0,0,0,0)));
    // T3: two readers in one beat, lowest channel is the first offender
    tbl.push_back(mk(1, 20, 3, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, ex(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0, 2'b11, 21, 12'h003, 1, 22, 12'h030, 2, ex(1,0,0,1,0,0,2,21)));
    tbl.push_back(mk(0, 0, 0, 2'b01, 20, 12'h000, 3, 0, 12'h000, 0, ex(0,1,0,1,0,0,2,21)));
    // T8: older reader and equal-order non-writer are not violations
    tbl.push_back(mk(1, 10, 5, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, ex(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0, 2'b01, 9, 12'h005, 1, 0, 12'h000, 0, ex(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0, 2'b01, 10, 12'h005, 1, 0, 12'h000, 0, ex(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0, 2'b01, 10, 12'h000, 5, 0, 12'h000, 0, ex(0,1,1,0,0,0,0,0)));
    // DONE ignores further bus traffic
    tbl.push_back(mk(0, 0, 0, 2'b01, 11, 12'h005, 1, 0, 12'h000, 0, ex(0,1,1,0,0,0,0,0)));

    reset_n           = 1'b0;
    bus.arm           = 1'b0;
    bus.tgt_order     = 32'd0;
    bus.tgt_reg       = 4'd0;
    bus.mfi_valid     = 2'b00;
    bus.mfi_order     = 64'd0;
    bus.mfi_src_addr  = 24'd0;
    bus.mfi_dest_addr = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset", ex(0,0,0,0,0,0,0,0));
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // T6: five violating reads saturate the 2-bit counter
    apply(mk(1, 30, 7, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, 40'd0));
    check("t6_arm", ex(1,0,0,0,0,0,0,0));
    apply(mk(0, 0, 0, 2'b11, 31, 12'h007, 1, 32, 12'h700, 1, 40'd0));
    check("t6_two", ex(1,0,0,1,0,0,2,31));
    apply(mk(0, 0, 0, 2'b11, 33, 12'h070, 1, 34, 12'h007, 1, 40'd0));
    check("t6_sat", ex(1,0,0,1,0,0,3,31));
    apply(mk(0, 0, 0, 2'b01, 35, 12'h007, 1, 0, 12'h000, 0, 40'd0));
    check("t6_hold", ex(1,0,0,1,0,0,3,31));

    // T5: timeout after 8 armed cycles, re-arm clears, hit on the 8th cycle wins
    apply(mk(1, 40, 2, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, 40'd0));
    for (int i = 0; i < 7; i++) apply(idle());
    check("t5_before", ex(1,0,0,0,0,0,0,0));
    apply(idle());
    check("t5_timeout", ex(0,0,0,0,1,0,0,0));
    apply(idle());
    apply(idle());
    check("t5_hold", ex(0,0,0,0,1,0,0,0));
    apply(mk(1, 50, 4, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, 40'd0));
    check("t5_rearm", ex(1,0,0,0,0,0,0,0));
    for (int i = 0; i < 7; i++) apply(idle());
    apply(mk(0, 0, 0, 2'b01, 50, 12'h000, 4, 0, 12'h000, 0, 40'd0));
    check("t5_hit_wins", ex(0,1,1,0,0,0,0,0));

    // T7: asynchronous reset mid-ARMED
    apply(mk(1, 60, 6, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, 40'd0));
    apply(mk(0, 0, 0, 2'b01, 61, 12'h006, 1, 0, 12'h000, 0, 40'd0));
    check("t7_viol", ex(1,0,0,1,0,0,1,61));
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_async", ex(0,0,0,0,0,0,0,0));
    @(negedge clock);
    reset_n = 1'b1;
    apply(idle());
    check("t7_idle", ex(0,0,0,0,0,0,0,0));

    // T4: arm with x0 rejected, then a valid arm clears arm_err
    apply(mk(1, 5, 0, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, 40'd0));
    check("t4_err", ex(0,0,0,0,0,1,0,0));
    apply(idle());
    check("t4_hold", ex(0,0,0,0,0,1,0,0));
    apply(mk(1, 5, 5, 2'b00, 0, 12'h000, 0, 0, 12'h000, 0, 40'd0));
    check("t4_clear", ex(1,0,0,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
